ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV32M/RV64M multiply/divide unit beside the EX stage ALU. Accepts one op from EX,
//  raises stallreq_o to freeze the pipeline while it iterates, then returns the result with wd_o.
//  Successor to the single-cycle madd/msub stall path: parametrised width, mul radix, all 8 M ops.
// PARAMETERS
//  XLEN      32  operand/result width (32 or 64)
//  MUL_STEP  1   multiplier bits retired per cycle (1, 2 or 4; must divide XLEN)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     asynchronous reset, active-low
//  start_i   in   1     op request from EX; sampled only in IDLE
//  annul_i   in   1     flush (branch/exception); kills op in flight
//  op_i      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  opa_i     in   XLEN  rs1 value
//  opb_i     in   XLEN  rs2 value
//  wd_i      in   5     destination register
//  result_o  out  XLEN  result; valid only while valid_o=1
//  wd_o      out  5     destination register of the returned result
//  valid_o   out  1     one-cycle result strobe (wreg for WB)
//  stallreq_o out 1     pipeline stall request
//  busy_o    out  1     state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; result_o=0, wd_o=0, valid_o=0, busy_o=0; all internal regs 0.
//  - FSM: IDLE -> MUL | DIV | DONE(special) ; MUL/DIV -> DONE when count hits 0 ; DONE -> IDLE.
//  - IDLE: start_i=1 & annul_i=0 latches op/operands/wd_i. Div-by-zero or signed overflow -> DONE
//    directly; DIV/DIVU/REM/REMU -> DIV, count=XLEN; MUL* -> MUL, count=XLEN/MUL_STEP.
//  - start_i while busy is ignored (EX is stalled and holds it; no queueing).
//  - Signed ops: |a|,|b| computed at accept; final sign fixed on entry to DONE. MULHSU: a signed,
//    b unsigned. Product is 2*XLEN; MUL returns low half, MULH* high half.
//  - MUL: shift-add, MUL_STEP bits/cycle. DIV: restoring, 1 quotient bit/cycle.
//  - Latency (accept cycle = 0, valid_o cycle = L): MUL* L=XLEN/MUL_STEP+1; DIV* L=XLEN+1;
//    special cases L=1. No early-out otherwise; latency is data-independent.
//  - DONE: valid_o=1 for exactly one cycle with result_o/wd_o; both hold last value afterwards.
//  - stallreq_o = (IDLE & start_i & ~annul_i) | MUL | DIV; low in DONE cycle so EX advances with it.
//  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
//  - Overflow DIV(-2^(XLEN-1), -1): quotient = dividend, REM = 0.
//  - REM sign follows dividend; quotient truncates toward zero.
//  - annul_i=1 in any state: -> IDLE next edge, valid_o stays 0, stallreq_o drops next cycle;
//    annul_i in DONE suppresses valid_o that cycle. annul_i with start_i in IDLE: op not accepted.
//  - Reset mid-op: op lost, no valid_o after rst deasserts.
// CONFIGURATION
//  - EX_MULDIV_FAST_MUL_EN defined: MUL* use a single combinational XLEN x XLEN multiplier;
//    IDLE -> DONE for all MUL*, L=1, MUL state and MUL_STEP unused. DIV* unchanged.
//  - Undefined: iterative multiplier as above (area-optimised default).
// TESTING (XLEN=32, MUL_STEP=1, macro undefined unless stated)
//  - MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid_o at cycle 33, stallreq_o high cycles 0..32.
//  - MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, valid_o at cycle 33.
//  - DIVU 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; all L=1.
//  - DIV started, annul_i at cycle 10 -> no valid_o, stallreq_o 0 at cycle 11; new start at 11 accepted.
//  - rst low at cycle 5 of MUL -> outputs 0 immediately; EX_MULDIV_FAST_MUL_EN: MUL 3x4 -> 12 at cycle 1.

Source files
------------

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ex_muldiv_if: EX-stage request / WB-return bundle for the ex_muldiv unit.
// master = EX pipeline side, slave = multiply/divide unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            annul_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] opa_i;
  logic [XLEN-1:0] opb_i;
  logic [4:0]      wd_i;
  logic [XLEN-1:0] result_o;
  logic [4:0]      wd_o;
  logic            valid_o;
  logic            stallreq_o;
  logic            busy_o;

  modport master (
    output start_i, annul_i, op_i, opa_i, opb_i, wd_i,
    input  result_o, wd_o, valid_o, stallreq_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, op_i, opa_i, opb_i, wd_i,
    output result_o, wd_o, valid_o, stallreq_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ex_muldiv: iterative RV32M/RV64M multiply/divide unit (shift-add mul, restoring div).
// Define EX_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] hi, lo, mcand, result;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic [4:0]      wd, res_wd;
  logic            neg_q, neg_r;
  logic            stall, valid;

  // Request decode: operand magnitudes and special-case results at accept
  logic            accept, sgn_a, sgn_b, neg_a, neg_b;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign accept   = (state == IDLE) & bus.start_i & ~bus.annul_i;
  assign sgn_a    = bus.op_i[2] ? ~bus.op_i[0] : (bus.op_i != 3'd3);
  assign sgn_b    = bus.op_i[2] ? ~bus.op_i[0] : ~bus.op_i[1];
  assign neg_a    = sgn_a & bus.opa_i[XLEN-1];
  assign neg_b    = sgn_b & bus.opb_i[XLEN-1];
  assign abs_a    = neg_a ? -bus.opa_i : bus.opa_i;
  assign abs_b    = neg_b ? -bus.opb_i : bus.opb_i;
  assign div_zero = (bus.opb_i == '0);
  assign ovf      = bus.op_i[2] & ~bus.op_i[0] & (bus.opa_i == MIN_INT) & (bus.opb_i == '1);
  assign special  = bus.op_i[2] & (div_zero | ovf);
  assign special_res = div_zero ? (bus.op_i[1] ? bus.opa_i : '1)
                                : (bus.op_i[1] ? '0 : bus.opa_i);

`ifdef EX_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_mag  = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
  assign fast_prod = (neg_a ^ neg_b) ? -fast_mag : fast_mag;
  assign fast_res  = (bus.op_i == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  // Shift-add step: {hi,lo} holds partial product above the unretired multiplier bits
  logic [XLEN+MUL_STEP-1:0] pp, sum;
  logic [2*XLEN-1:0]        mul_nxt, prod;
  logic [XLEN-1:0]          mul_res;

  assign pp      = {{MUL_STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, lo[MUL_STEP-1:0]};
  assign sum     = {{MUL_STEP{1'b0}}, hi} + pp;
  assign mul_nxt = {sum, lo[XLEN-1:MUL_STEP]};
  assign prod    = neg_q ? -mul_nxt : mul_nxt;
  assign mul_res = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring step: hi = partial remainder, lo = dividend shifting out / quotient shifting in
  logic [XLEN:0]   shl, diff;
  logic            qbit;
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;

  assign shl     = {hi, lo[XLEN-1]};
  assign diff    = shl - {1'b0, mcand};
  assign qbit    = ~diff[XLEN];
  assign rem_nxt = qbit ? diff[XLEN-1:0] : shl[XLEN-1:0];
  assign quo_nxt = {lo[XLEN-2:0], qbit};
  assign div_res = op[1] ? (neg_r ? -rem_nxt : rem_nxt) : (neg_q ? -quo_nxt : quo_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (bus.op_i[2]) state_nxt = special ? DONE : DIV;
          else begin
`ifdef EX_MULDIV_FAST_MUL_EN
            state_nxt = DONE;
`else
            state_nxt = MUL;
`endif
          end
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.annul_i) begin
      state_nxt = IDLE;
      valid     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      count  <= '0;
      op     <= '0;
      wd     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      res_wd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= bus.op_i;
            wd    <= bus.wd_i;
            count <= bus.op_i[2] ? CW'(XLEN) : CW'(XLEN / MUL_STEP);
            hi    <= '0;
            lo    <= bus.op_i[2] ? abs_a : abs_b;
            mcand <= bus.op_i[2] ? abs_b : abs_a;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            if (special) begin
              result <= special_res;
              res_wd <= bus.wd_i;
            end
`ifdef EX_MULDIV_FAST_MUL_EN
            else if (!bus.op_i[2]) begin
              result <= fast_res;
              res_wd <= bus.wd_i;
            end
`endif
          end
        end
        MUL: begin
          if (!bus.annul_i) begin
            hi    <= mul_nxt[2*XLEN-1:XLEN];
            lo    <= mul_nxt[XLEN-1:0];
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              result <= mul_res;
              res_wd <= wd;
            end
          end
        end
        DIV: begin
          if (!bus.annul_i) begin
            hi    <= rem_nxt;
            lo    <= quo_nxt;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              result <= div_res;
              res_wd <= wd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o   = result;
  assign bus.wd_o       = res_wd;
  assign bus.valid_o    = valid;
  assign bus.stallreq_o = stall;
  assign bus.busy_o     = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// tb_ex_muldiv: vector table + random ops against a reference model, scoreboard-checked,
// plus hand sequences for busy-start, annul and mid-op reset.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  ex_muldiv_if #(.XLEN(32)) bus ();
  ex_muldiv #(.XLEN(32), .MUL_STEP(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wd;
    int          c0;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ov;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
`ifdef EX_MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Scoreboard monitor: every valid_o must match the oldest outstanding request
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && bus.valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: actual result=%0h wd=%0d, required no result", bus.result_o, bus.wd_o);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result_o, e.res);
        chk("wd", bus.wd_o, e.wd);
        chk("latency", cyc - e.c0, e.lat);
      end
    end
  end

  // Called just after a negedge; drives the op, follows stallreq_o, checks completion
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic [31:0] expv, input bit poke);
    int   L;
    bit   stall_bad;
    exp_t e;
    L = lat_of(op, a, b);
    stall_bad = 1'b0;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.wd_i    = wd;
    e.res = expv; e.wd = wd; e.c0 = cyc; e.lat = L;
    sb.push_back(e);
    #1;
    if (bus.stallreq_o !== 1'b1) stall_bad = 1'b1;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
      if (poke && k == 3) begin
        bus.start_i = 1'b1; bus.op_i = 3'd0; bus.opa_i = 32'd9; bus.opb_i = 32'd9; bus.wd_i = 5'd31;
      end
      if (poke && k == 4) bus.start_i = 1'b0;
      #1;
      if (bus.stallreq_o !== (k < L)) stall_bad = 1'b1;
    end
    chk("stall_profile", stall_bad, 0);
    chk("result_returned", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    #1;
    chk("strobe_one_cycle", bus.valid_o, 0);
    chk("idle_after", bus.busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tbl[6]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
    tbl[7]  = '{3'd7, 32'd5,          32'd0,         32'd5};
    tbl[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    tbl[10] = '{3'd0, 32'd3,          32'd4,         32'd12};
    tbl[11] = '{3'd5, 32'd100,        32'd7,         32'd14};
    tbl[12] = '{3'd7, 32'd100,        32'd7,         32'd2};
    tbl[13] = '{3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF};
    tbl[14] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
    tbl[15] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0};
    tbl[16] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[17] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[18] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1};
    tbl[19] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};

    rst = 1'b0;
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.op_i = '0;
    bus.opa_i = '0; bus.opb_i = '0; bus.wd_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_result", bus.result_o, 0);
    chk("reset_wd", bus.wd_o, 0);
    chk("reset_valid", bus.valid_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].exp, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op(op, a, b, 5'($urandom_range(1, 31)), model(op, a, b), 1'b0);
    end

    // start while busy must be ignored
    run_op(3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, 1'b1);
    run_op(3'd0, 32'd6, 32'd7, 5'd18, 32'd42, 1'b1);

    // annul mid-divide at cycle 10, then new op at cycle 11
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.opa_i = 32'd77; bus.opb_i = 32'd5; bus.wd_i = 5'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
      if (k == 10) bus.annul_i = 1'b1;
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    #1;
    chk("annul_stall_drop", bus.stallreq_o, 0);
    chk("annul_idle", bus.busy_o, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd11, 32'd12, 1'b0);

    // annul during DONE suppresses the strobe
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.opa_i = 32'd100; bus.opb_i = 32'd7; bus.wd_i = 5'd3;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
    end
    @(posedge clk);
    #1 bus.annul_i = 1'b1;
    #1;
    chk("annul_done_valid", bus.valid_o, 0);
    @(posedge clk);
    #1 bus.annul_i = 1'b0;
    chk("annul_done_idle", bus.busy_o, 0);

    // reset at cycle 5 of a multiply
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd0; bus.opa_i = 32'd123; bus.opb_i = 32'd456; bus.wd_i = 5'd7;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midreset_result", bus.result_o, 0);
    chk("midreset_wd", bus.wd_o, 0);
    chk("midreset_valid", bus.valid_o, 0);
    chk("midreset_busy", bus.busy_o, 0);
    chk("midreset_stall", bus.stallreq_o, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("post_reset_idle", bus.busy_o, 0);
    chk("post_reset_result", bus.result_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
